// File: rtl/pipe_latch.sv
// pipe_latch: pipeline stage latch between two stages, with a 1-entry
// (SKID=0) or 2-entry skid (SKID=1) valid/ready handshake.
//
// Ports:
//   CLK        rising-edge clock
//   nRST       synchronous active-low reset
//   in_valid   upstream payload present
//   in_data    upstream payload (WIDTH bits)
//   in_ready   latch can accept this cycle (registered decode when SKID=1)
//   out_valid  latch holds a payload
//   out_data   oldest held payload, BUBBLE when empty
//   out_ready  downstream consumes out_data this cycle
//   flush      squash all held payloads
//   occupancy  number of held payloads (0..2)
module pipe_latch #(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and data-load strobes
  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next      = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && !w_drain) begin
          // Unreachable with SKID=0: there in_ready in ONE implies out_ready.
          if (SKID != 0) begin
            w_next      = S_TWO;
            w_load_skid = 1'b1;
          end
        end else if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_drain) begin
          w_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_next           = S_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
    // Flush wins over any transition; data registers are left stale.
    if (flush) begin
      w_next      = S_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  // Outputs decoded from registered state (plus out_ready when SKID=0)
  always_comb begin
    out_valid = (r_state != S_EMPTY);
    occupancy = r_state;
    out_data  = out_valid ? r_main : BUBBLE;
    if (SKID != 0) begin
      in_ready = (r_state != S_TWO);
    end else begin
      in_ready = (r_state == S_EMPTY) | out_ready;
    end
  end

  // Main (head) register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_main <= '0;
    end else if (w_load_main) begin
      r_main <= w_main_from_skid ? w_skid : in_data;
    end
  end

  // Skid register exists only in the 2-entry configuration
  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] r_skid;
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          r_skid <= '0;
        end else if (w_load_skid) begin
          r_skid <= in_data;
        end
      end
      assign w_skid = r_skid;
    end else begin : g_no_skid
      logic w_unused_skid_load;
      assign w_unused_skid_load = w_load_skid;
      assign w_skid             = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_latch.sv
// Directed and randomized checks of pipe_latch in both SKID configurations.
module tb_pipe_latch;

  localparam logic [31:0] BUB_A = 32'hB0B0_B0B0;
  localparam logic [31:0] BUB_B = 32'h0000_DEAD;

  logic        CLK = 1'b0;
  logic        nRST;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 CLK = ~CLK;

  pipe_latch #(.WIDTH(32), .SKID(1), .BUBBLE(BUB_A)) u_dut_a (
    .CLK(CLK), .nRST(nRST),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .flush(a_flush), .occupancy(a_occ)
  );

  pipe_latch #(.WIDTH(32), .SKID(0), .BUBBLE(BUB_B)) u_dut_b (
    .CLK(CLK), .nRST(nRST),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .flush(b_flush), .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_a(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = rdy;
    a_flush     = fl;
  endtask

  initial begin
    nRST = 1'b0;
    send_a(1'b0, 32'h0, 1'b0, 1'b0);
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_a_occ",   32'(a_occ), 32'd0);
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data",  a_out_data, BUB_A);
    chk("rst_a_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_ready", 32'(b_in_ready), 32'd1);
    chk("rst_b_data",  b_out_data, BUB_B);
    nRST = 1'b1;

    // Streaming at one payload per cycle
    send_a(1'b1, 32'h1, 1'b1, 1'b0); tick();
    chk("str_d1", a_out_data, 32'h1); chk("str_o1", 32'(a_occ), 32'd1);
    send_a(1'b1, 32'h2, 1'b1, 1'b0); tick();
    chk("str_d2", a_out_data, 32'h2); chk("str_o2", 32'(a_occ), 32'd1);
    send_a(1'b1, 32'h3, 1'b1, 1'b0); tick();
    chk("str_d3", a_out_data, 32'h3); chk("str_o3", 32'(a_occ), 32'd1);
    send_a(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("str_empty_occ", 32'(a_occ), 32'd0); chk("str_empty_data", a_out_data, BUB_A);

    // Backpressure fills skid, then drains in order
    send_a(1'b1, 32'hA, 1'b0, 1'b0); tick();
    chk("bp_o1", 32'(a_occ), 32'd1); chk("bp_d1", a_out_data, 32'hA);
    chk("bp_r1", 32'(a_in_ready), 32'd1);
    send_a(1'b1, 32'hB, 1'b0, 1'b0); tick();
    chk("bp_o2", 32'(a_occ), 32'd2); chk("bp_r2", 32'(a_in_ready), 32'd0);
    chk("bp_d2", a_out_data, 32'hA);
    send_a(1'b1, 32'hF, 1'b0, 1'b0); tick();
    chk("bp_hold_o", 32'(a_occ), 32'd2); chk("bp_hold_d", a_out_data, 32'hA);
    send_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_rise_d", a_out_data, 32'hA);
    tick();
    chk("bp_dB", a_out_data, 32'hB); chk("bp_oB", 32'(a_occ), 32'd1);
    chk("bp_rB", 32'(a_in_ready), 32'd1);
    tick();
    chk("bp_end_o", 32'(a_occ), 32'd0); chk("bp_end_d", a_out_data, BUB_A);

    // Flush while full, with upstream offering 0xC
    send_a(1'b1, 32'h11, 1'b0, 1'b0); tick();
    send_a(1'b1, 32'h22, 1'b0, 1'b0); tick();
    chk("fl_full", 32'(a_occ), 32'd2);
    send_a(1'b1, 32'hC, 1'b1, 1'b1); tick();
    send_a(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl_o", 32'(a_occ), 32'd0); chk("fl_v", 32'(a_out_valid), 32'd0);
    chk("fl_d", a_out_data, BUB_A);
    tick();
    chk("fl_d_later", a_out_data, BUB_A);

    // Flush in ONE discards the payload accepted in the same cycle
    send_a(1'b1, 32'h33, 1'b0, 1'b0); tick();
    chk("fl1_o", 32'(a_occ), 32'd1);
    send_a(1'b1, 32'h44, 1'b0, 1'b1);
    chk("fl1_ready", 32'(a_in_ready), 32'd1);
    tick();
    send_a(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl1_o2", 32'(a_occ), 32'd0); chk("fl1_d", a_out_data, BUB_A);

    // Reset while full, then normal delivery
    send_a(1'b1, 32'h55, 1'b0, 1'b0); tick();
    send_a(1'b1, 32'h66, 1'b0, 1'b0); tick();
    chk("mr_full", 32'(a_occ), 32'd2);
    nRST = 1'b0; send_a(1'b1, 32'h99, 1'b1, 1'b0); tick();
    nRST = 1'b1; send_a(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mr_o", 32'(a_occ), 32'd0); chk("mr_d", a_out_data, BUB_A);
    chk("mr_r", 32'(a_in_ready), 32'd1);
    send_a(1'b1, 32'h77, 1'b1, 1'b0); tick();
    chk("mr_post_d", a_out_data, 32'h77); chk("mr_post_o", 32'(a_occ), 32'd1);
    send_a(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("mr_post_empty", 32'(a_occ), 32'd0);

    // SKID=0: combinational in_ready from out_ready
    b_in_valid = 1'b1; b_in_data = 32'h5; b_out_ready = 1'b0; tick();
    chk("b_d5", b_out_data, 32'h5); chk("b_o5", 32'(b_occ), 32'd1);
    b_in_data = 32'h6; #1;
    chk("b_notready", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1; #1;
    chk("b_ready_same", 32'(b_in_ready), 32'd1);
    tick();
    chk("b_d6", b_out_data, 32'h6); chk("b_o6", 32'(b_occ), 32'd1);
    b_in_valid = 1'b0; tick();
    chk("b_empty_d", b_out_data, BUB_B); chk("b_empty_o", 32'(b_occ), 32'd0);

    // Randomized traffic against reference queues
    qa.delete(); qb.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic ra, rb, acc;
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      a_out_ready = 1'($urandom_range(0, 2) != 0);
      a_flush     = 1'($urandom_range(0, 31) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_data   = $urandom;
      b_out_ready = 1'($urandom_range(0, 1));
      b_flush     = 1'($urandom_range(0, 31) == 0);
      #1;
      ra = (qa.size() < 2);
      rb = (qb.size() == 0) || b_out_ready;
      chk("rnd_a_occ",   32'(a_occ), 32'(qa.size()));
      chk("rnd_a_ready", 32'(a_in_ready), 32'(ra));
      chk("rnd_a_data",  a_out_data, (qa.size() != 0) ? qa[0] : BUB_A);
      chk("rnd_b_occ",   32'(b_occ), 32'(qb.size()));
      chk("rnd_b_ready", 32'(b_in_ready), 32'(rb));
      chk("rnd_b_data",  b_out_data, (qb.size() != 0) ? qb[0] : BUB_B);
      acc = a_in_valid && ra;
      if (a_flush) qa.delete();
      else begin
        if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
        if (acc) qa.push_back(a_in_data);
      end
      acc = b_in_valid && rb;
      if (b_flush) qb.delete();
      else begin
        if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());
        if (acc) qb.push_back(b_in_data);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
